// File: rtl/bitwise_gate_pipe.sv
// Pipelined bitwise logic unit: eight selectable ops on two WIDTH-bit operands, STAGES deep, valid/ready on both sides.
// Optional completed-transfer counter enabled by defining BITWISE_GATE_PIPE_TXN_CNT_EN.
module bitwise_gate_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             c_zero,
`ifdef BITWISE_GATE_PIPE_TXN_CNT_EN
    output logic [15:0]      txn_count,
    input  logic             clr_count,
`endif
    output logic             busy
);

    localparam int unsigned LAST = STAGES - 1;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOTA = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    logic [WIDTH-1:0]  res;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] load;
    logic [STAGES:0]   vld_src;
    logic [WIDTH-1:0]  dat_q [STAGES];
    logic              zf_q  [STAGES];

    always_comb begin
        res = a;
        case (op_e'(op))
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_NOR:  res = ~(a | b);
            OP_NAND: res = ~(a & b);
            OP_XOR:  res = a ^ b;
            OP_XNOR: res = ~(a ^ b);
            OP_NOTA: res = ~a;
            OP_PASS: res = a;
            default: res = a;
        endcase
    end

    // Stage k can load unless it and every stage after it are occupied and the output is stalled.
    assign vld_src = {vld_q, in_valid};

    always_comb begin
        load  = '0;
        vld_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            load[k]  = out_ready || !(&(vld_q | STAGES'((1 << k) - 1)));
            vld_d[k] = load[k] ? vld_src[k] : vld_q[k];
        end
    end

    assign in_ready = load[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            busy  <= 1'b0;
        end else begin
            vld_q <= vld_d;
            busy  <= |vld_d;
        end
    end

    // Data registers only move when a real entry arrives, so idle operands never touch state.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dat_q[0] <= '0;
                    zf_q[0]  <= 1'b0;
                end else if (load[0] && in_valid) begin
                    dat_q[0] <= res;
                    zf_q[0]  <= ~|res;
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dat_q[k] <= '0;
                    zf_q[k]  <= 1'b0;
                end else if (load[k] && vld_q[k-1]) begin
                    dat_q[k] <= dat_q[k-1];
                    zf_q[k]  <= zf_q[k-1];
                end
            end
        end
    end

    assign out_valid = vld_q[LAST];
    assign c         = dat_q[LAST];
    assign c_zero    = zf_q[LAST];

`ifdef BITWISE_GATE_PIPE_TXN_CNT_EN
    // Saturating count of output handshakes; clear takes priority over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count <= '0;
        end else if (clr_count) begin
            txn_count <= '0;
        end else if (out_valid && out_ready && (txn_count != 16'hFFFF)) begin
            txn_count <= txn_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bitwise_gate_pipe.sv
// Self-checking bench for bitwise_gate_pipe: directed truth-table/flow-control steps plus random traffic vs a queue model.
module tb_bitwise_gate_pipe;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned STAGES = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, out_valid, out_ready, c_zero, busy;
    logic [WIDTH-1:0] a, b, c;
    logic [2:0]       op;
    logic             clr_count;
`ifdef BITWISE_GATE_PIPE_TXN_CNT_EN
    logic [15:0]      txn_count;
`endif

    bitwise_gate_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .c_zero    (c_zero),
`ifdef BITWISE_GATE_PIPE_TXN_CNT_EN
        .txn_count (txn_count),
        .clr_count (clr_count),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] v;
        int               t;
    } ent_t;

    ent_t             q[$];
    logic [WIDTH-1:0] got[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    int               n_acc = 0;
    int               n_rel = 0;
    int               model_cnt = 0;
    int               acc0, rel0;
    logic [WIDTH-1:0] tt [8];

    function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return ~(x | y);
            3'd3:    return ~(x & y);
            3'd4:    return x ^ y;
            3'd5:    return ~(x ^ y);
            3'd6:    return ~x;
            default: return x;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the queue model, then advance the model by the handshakes it predicts.
    task automatic cycle();
        logic exp_ir, exp_ov;
        #1;
        exp_ir = (q.size() < int'(STAGES)) || out_ready;
        exp_ov = (q.size() != 0) && ((cyc - q[0].t) >= int'(STAGES));
        chk("in_ready", 64'(in_ready), 64'(exp_ir));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        chk("busy", 64'(busy), 64'(q.size() != 0));
        if (exp_ov) begin
            chk("c", 64'(c), 64'(q[0].v));
            chk("c_zero", 64'(c_zero), 64'(q[0].v == '0));
        end
`ifdef BITWISE_GATE_PIPE_TXN_CNT_EN
        chk("txn_count", 64'(txn_count), 64'(model_cnt));
`endif
        if (exp_ov && out_ready) begin
            got.push_back(q[0].v);
            void'(q.pop_front());
            n_rel++;
        end
        if (clr_count) model_cnt = 0;
        else if (exp_ov && out_ready && model_cnt < 65535) model_cnt++;
        if (in_valid && exp_ir) begin
            q.push_back('{v: ref_op(op, a, b), t: cyc});
            n_acc++;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        in_valid = v;
        op       = o;
        a        = x;
        b        = y;
    endtask

    initial begin
        tt = '{8'hC0, 8'hFC, 8'h03, 8'h3F, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_count = 1'b0;
        a = '0; b = '0; op = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_c", 64'(c), 64'd0);
        chk("rst_c_zero", 64'(c_zero), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Truth table, back-to-back ops 0..7
        got.delete();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 8'hF0, 8'hCC);
            cycle();
        end
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        repeat (4) cycle();
        chk("tt_count", 64'(got.size()), 64'd8);
        for (int i = 0; i < 8 && i < got.size(); i++) chk($sformatf("tt_op%0d", i), 64'(got[i]), 64'(tt[i]));

        // Zero flag
        got.delete();
        drive(1'b1, 3'd0, 8'hAA, 8'h55); cycle();
        drive(1'b1, 3'd1, 8'hAA, 8'h55); cycle();
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        repeat (3) cycle();
        chk("zf_count", 64'(got.size()), 64'd2);
        if (got.size() == 2) begin
            chk("zf_and", 64'(got[0]), 64'h00);
            chk("zf_or", 64'(got[1]), 64'hFF);
        end

        // Backpressure: third transaction stalls until the consumer drains
        got.delete();
        acc0 = n_acc;
        out_ready = 1'b0;
        drive(1'b1, 3'd4, 8'h12, 8'h34); cycle();
        drive(1'b1, 3'd3, 8'h56, 8'h78); cycle();
        drive(1'b1, 3'd1, 8'h9A, 8'hBC); cycle(); cycle(); cycle();
        chk("bp_accepted", 64'(n_acc - acc0), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        cycle();
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        repeat (4) cycle();
        chk("bp_out", 64'(got.size()), 64'd3);
        if (got.size() == 3) chk("bp_third", 64'(got[2]), 64'(8'h9A | 8'hBC));

        // Full pipe with simultaneous accept and release for 10 cycles
        out_ready = 1'b0;
        repeat (2) begin drive(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom)); cycle(); end
        out_ready = 1'b1;
        acc0 = n_acc; rel0 = n_rel;
        repeat (10) begin drive(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom)); cycle(); end
        chk("full_in", 64'(n_acc - acc0), 64'd10);
        chk("full_out", 64'(n_rel - rel0), 64'd10);
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        repeat (4) cycle();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            out_ready = 1'($urandom_range(0, 3) != 0);
            cycle();
        end
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        out_ready = 1'b1;
        repeat (4) cycle();

        // Asynchronous reset with two entries in flight
        out_ready = 1'b0;
        drive(1'b1, 3'd7, 8'h5A, 8'h00); cycle();
        drive(1'b1, 3'd7, 8'hA5, 8'h00); cycle();
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_c", 64'(c), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        q.delete();
        model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) cycle();

`ifdef BITWISE_GATE_PIPE_TXN_CNT_EN
        clr_count = 1'b1; cycle(); clr_count = 1'b0;
        repeat (5) begin drive(1'b1, 3'd0, 8'($urandom), 8'($urandom)); cycle(); end
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        repeat (3) cycle();
        chk("cnt_five", 64'(txn_count), 64'd5);
        drive(1'b1, 3'd1, 8'h01, 8'h02); cycle();
        drive(1'b0, 3'd0, 8'h00, 8'h00); cycle();
        clr_count = 1'b1; cycle(); clr_count = 1'b0;
        cycle();
        chk("cnt_clr", 64'(txn_count), 64'd0);
        drive(1'b1, 3'd7, 8'h11, 8'h00);
        repeat (65540) cycle();
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        repeat (3) cycle();
        chk("cnt_sat", 64'(txn_count), 64'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
